// File: rtl/fp_mac_pkg.sv
// Shared floating-point types and constants for the MAC datapath (bfloat16 by default).
package fp_mac_pkg;

  localparam int unsigned BIT_WIDTH_DEFAULT  = 16;
  localparam int unsigned EXP_WIDTH_DEFAULT  = 8;
  localparam int unsigned MANT_WIDTH_DEFAULT = 7;

  typedef logic [BIT_WIDTH_DEFAULT-1:0] fp_word_t;

  typedef struct packed {
    logic exception;
    logic overflow;
    logic underflow;
  } fp_flags_t;

  localparam fp_word_t FP_ONE  = 16'h3F80;
  localparam fp_word_t FP_ZERO = 16'h0000;

endpackage

// File: rtl/fp_mul_arbiter_if.sv
// Requester-side and response-side handshake bundle of the shared multiplier arbiter.
interface fp_mul_arbiter_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned BIT_WIDTH = 16
);
  localparam int unsigned ID_WIDTH = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*BIT_WIDTH-1:0] req_a;
  logic [NUM_REQ*BIT_WIDTH-1:0] req_b;
  logic                         resp_valid;
  logic                         resp_ready;
  logic [ID_WIDTH-1:0]          resp_id;
  logic [BIT_WIDTH-1:0]         resp_result;
  logic                         resp_exception;
  logic                         resp_overflow;
  logic                         resp_underflow;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_result,
           resp_exception, resp_overflow, resp_underflow
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_result,
           resp_exception, resp_overflow, resp_underflow
  );

endinterface

// File: rtl/fp_multiplier.sv
// Combinational floating-point multiplier; truncates the product, flushes subnormal results to zero.
module fp_multiplier #(
  parameter int unsigned BIT_WIDTH  = 16,
  parameter int unsigned EXP_WIDTH  = 8,
  parameter int unsigned MANT_WIDTH = 7
) (
  input  logic [BIT_WIDTH-1:0] a_operand,
  input  logic [BIT_WIDTH-1:0] b_operand,
  output logic [BIT_WIDTH-1:0] result,
  output logic                 Exception,
  output logic                 Overflow,
  output logic                 Underflow
);
  localparam int unsigned SIG_W  = MANT_WIDTH + 1;
  localparam int unsigned PROD_W = 2 * SIG_W;
  localparam int unsigned ESUM_W = EXP_WIDTH + 2;
  localparam int unsigned BIAS   = (1 << (EXP_WIDTH - 1)) - 1;

  logic                  sign;
  logic [EXP_WIDTH-1:0]  a_exp, b_exp;
  logic [SIG_W-1:0]      a_sig, b_sig;
  logic [PROD_W-1:0]     product;
  logic                  norm;
  logic [MANT_WIDTH-1:0] mant;
  logic [ESUM_W-1:0]     exp_sum;
  logic                  is_zero;
  logic                  unused_prod_lsb;

  assign sign    = a_operand[BIT_WIDTH-1] ^ b_operand[BIT_WIDTH-1];
  assign a_exp   = a_operand[BIT_WIDTH-2 -: EXP_WIDTH];
  assign b_exp   = b_operand[BIT_WIDTH-2 -: EXP_WIDTH];
  assign a_sig   = {|a_exp, a_operand[MANT_WIDTH-1:0]};
  assign b_sig   = {|b_exp, b_operand[MANT_WIDTH-1:0]};
  assign product = PROD_W'(a_sig) * PROD_W'(b_sig);
  assign norm    = product[PROD_W-1];
  assign mant    = norm ? product[PROD_W-2 -: MANT_WIDTH] : product[PROD_W-3 -: MANT_WIDTH];
  assign unused_prod_lsb = ^product[MANT_WIDTH-1:0];

  // Top bit of exp_sum set means the biased exponent went negative.
  assign exp_sum = ESUM_W'(a_exp) + ESUM_W'(b_exp) + ESUM_W'(norm) - ESUM_W'(BIAS);
  assign is_zero = (a_operand[BIT_WIDTH-2:0] == '0) || (b_operand[BIT_WIDTH-2:0] == '0);

  assign Exception = (&a_exp) | (&b_exp);
  assign Overflow  = !Exception && !is_zero && !exp_sum[ESUM_W-1] &&
                     (exp_sum[ESUM_W-2:0] >= (ESUM_W-1)'((1 << EXP_WIDTH) - 1));
  assign Underflow = !Exception && !is_zero && (exp_sum[ESUM_W-1] || (exp_sum == '0));

  always_comb begin
    if (Exception) begin
      result = '0;
    end else if (Overflow) begin
      result = {sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
    end else if (is_zero || Underflow) begin
      result = {sign, {(BIT_WIDTH-1){1'b0}}};
    end else begin
      result = {sign, exp_sum[EXP_WIDTH-1:0], mant};
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the scan at rr_ptr, pointer moves past each winner.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQ-1:0]  req,
  input  logic                enable,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] grant_idx
);
  logic [ID_WIDTH-1:0] rr_ptr;
  logic                any_grant;

  always_comb begin
    logic [ID_WIDTH:0] pos;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    pos       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, rr_ptr} + (ID_WIDTH+1)'(k);
      if (pos >= (ID_WIDTH+1)'(NUM_REQ)) pos = pos - (ID_WIDTH+1)'(NUM_REQ);
      if (enable && !any_grant && req[pos[ID_WIDTH-1:0]]) begin
        any_grant                  = 1'b1;
        grant[pos[ID_WIDTH-1:0]]   = 1'b1;
        grant_idx                  = pos[ID_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (any_grant) begin
      rr_ptr <= (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + ID_WIDTH'(1);
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one fp_multiplier among NUM_REQ requesters through a two-stage tagged pipeline.
// FP_MUL_STICKY_FLAGS_EN adds sticky status flags accumulated on each output handshake.
module fp_mul_arbiter import fp_mac_pkg::*; #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned BIT_WIDTH  = BIT_WIDTH_DEFAULT,
  parameter int unsigned EXP_WIDTH  = EXP_WIDTH_DEFAULT,
  parameter int unsigned MANT_WIDTH = MANT_WIDTH_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  fp_mul_arbiter_if.slave bus,
  input  logic            status_clr,
  output logic            status_exception,
  output logic            status_overflow,
  output logic            status_underflow,
  output logic            busy
);
  localparam int unsigned ID_WIDTH = $clog2(NUM_REQ);

  logic                 adv1, adv2;
  logic [NUM_REQ-1:0]   grant;
  logic [ID_WIDTH-1:0]  grant_idx;
  logic                 grant_any;
  logic [BIT_WIDTH-1:0] gnt_a, gnt_b;

  logic                 s1_valid;
  logic [BIT_WIDTH-1:0] s1_a, s1_b;
  logic [ID_WIDTH-1:0]  s1_id;

  logic                 s2_valid;
  logic [BIT_WIDTH-1:0] s2_result;
  logic [ID_WIDTH-1:0]  s2_id;
  fp_flags_t            s2_flags;

  logic [BIT_WIDTH-1:0] mul_result;
  logic                 mul_exc, mul_ovf, mul_unf;

  assign adv2 = !s2_valid || bus.resp_ready;
  assign adv1 = !s1_valid || adv2;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus.req_valid),
    .enable    (adv1),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign bus.req_ready = grant;
  assign grant_any     = |grant;

  always_comb begin
    gnt_a = '0;
    gnt_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gnt_a = bus.req_a[i*BIT_WIDTH +: BIT_WIDTH];
        gnt_b = bus.req_b[i*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
    end else if (adv1) begin
      s1_valid <= grant_any;
      if (grant_any) begin
        s1_a  <= gnt_a;
        s1_b  <= gnt_b;
        s1_id <= grant_idx;
      end
    end
  end

  fp_multiplier #(
    .BIT_WIDTH  (BIT_WIDTH),
    .EXP_WIDTH  (EXP_WIDTH),
    .MANT_WIDTH (MANT_WIDTH)
  ) u_fp_multiplier (
    .a_operand (s1_a),
    .b_operand (s1_b),
    .result    (mul_result),
    .Exception (mul_exc),
    .Overflow  (mul_ovf),
    .Underflow (mul_unf)
  );

  // Data only loads with a valid entry so resp_* keeps its last value while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_id     <= '0;
      s2_flags  <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result <= mul_result;
        s2_id     <= s1_id;
        s2_flags  <= '{exception: mul_exc, overflow: mul_ovf, underflow: mul_unf};
      end
    end
  end

  assign bus.resp_valid     = s2_valid;
  assign bus.resp_id        = s2_id;
  assign bus.resp_result    = s2_result;
  assign bus.resp_exception = s2_flags.exception;
  assign bus.resp_overflow  = s2_flags.overflow;
  assign bus.resp_underflow = s2_flags.underflow;
  assign busy               = s1_valid || s2_valid;

`ifdef FP_MUL_STICKY_FLAGS_EN
  fp_flags_t status_q, status_d;

  // Clear is applied first so a flag arriving in the same cycle survives.
  always_comb begin
    status_d = status_q;
    if (status_clr) status_d = '0;
    if (s2_valid && bus.resp_ready) status_d = status_d | s2_flags;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
    end else begin
      status_q <= status_d;
    end
  end

  assign status_exception = status_q.exception;
  assign status_overflow  = status_q.overflow;
  assign status_underflow = status_q.underflow;
`else
  logic unused_status_clr;
  assign unused_status_clr = status_clr;
  assign status_exception  = 1'b0;
  assign status_overflow   = 1'b0;
  assign status_underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Scoreboard bench for fp_mul_arbiter: per-requester op lists, expected results queued at grant.
module tb_fp_mul_arbiter;
  import fp_mac_pkg::*;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned BW      = BIT_WIDTH_DEFAULT;
  localparam int unsigned OPS_MAX = 32;

  typedef struct packed {
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    logic [BW-1:0] res;
    logic [2:0]    flg;
  } op_t;

  typedef struct {
    int unsigned   id;
    logic [BW-1:0] res;
    logic [2:0]    flg;
    int            cyc;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n;
  logic status_clr;
  logic status_exception, status_overflow, status_underflow, busy;

  fp_mul_arbiter_if #(.NUM_REQ(NUM_REQ), .BIT_WIDTH(BW)) bus ();

  fp_mul_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .BIT_WIDTH  (BW),
    .EXP_WIDTH  (EXP_WIDTH_DEFAULT),
    .MANT_WIDTH (MANT_WIDTH_DEFAULT)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus),
    .status_clr       (status_clr),
    .status_exception (status_exception),
    .status_overflow  (status_overflow),
    .status_underflow (status_underflow),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  op_t         ops [NUM_REQ][OPS_MAX];
  int          head [NUM_REQ];
  int          tail [NUM_REQ];
  sb_t         sb [$];
  int          gnt_log [$];
  int          cyc;
  int          n_resp;
  int          n_checks;
  int          n_fail;
  bit          lat_chk;
  bit          held_v;
  logic [21:0] held;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_op(input int r, input logic [BW-1:0] a, input logic [BW-1:0] b,
                         input logic [BW-1:0] res, input logic [2:0] flg);
    ops[r][tail[r]] = '{a: a, b: b, res: res, flg: flg};
    tail[r]++;
  endtask

  function automatic bit pending();
    for (int i = 0; i < NUM_REQ; i++) if (head[i] < tail[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (head[i] < tail[i]) begin
        bus.req_valid[i]         = 1'b1;
        bus.req_a[i*BW +: BW]    = ops[i][head[i]].a;
        bus.req_b[i*BW +: BW]    = ops[i][head[i]].b;
      end else begin
        bus.req_valid[i] = 1'b0;
      end
    end
  endtask

  // Observe mid-cycle, then advance past the next rising edge and re-drive inputs.
  task automatic tick();
    sb_t         e;
    logic [21:0] cur;
    @(negedge clk);
    cyc++;
    check_eq("onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
    cur = {bus.resp_valid, bus.resp_id, bus.resp_result,
           bus.resp_exception, bus.resp_overflow, bus.resp_underflow};
    if (held_v) check_eq("resp_hold", 32'(cur), 32'(held));
    held_v = bus.resp_valid && !bus.resp_ready;
    held   = cur;
    if (bus.resp_valid && bus.resp_ready) begin
      n_resp++;
      if (sb.size() == 0) begin
        check_eq("spurious_resp", 32'(cur), 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("resp_id", 32'(bus.resp_id), e.id);
        check_eq("resp_result", 32'(bus.resp_result), 32'(e.res));
        check_eq("resp_flags",
                 32'({bus.resp_exception, bus.resp_overflow, bus.resp_underflow}), 32'(e.flg));
        if (lat_chk) check_eq("latency", cyc - e.cyc, 32'd2);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req_valid[i] && bus.req_ready[i]) begin
        e.id  = i;
        e.res = ops[i][head[i]].res;
        e.flg = ops[i][head[i]].flg;
        e.cyc = cyc;
        sb.push_back(e);
        gnt_log.push_back(i);
        head[i]++;
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain(input int budget, output int used);
    used = 0;
    while ((pending() || sb.size() != 0) && used < budget) begin
      tick();
      used++;
    end
    if (pending() || sb.size() != 0) check_eq("drain_timeout", 32'd0, 32'd1);
  endtask

  int used;
  int r0;
  int exp_bp [3] = '{3, 0, 1};

  initial begin
    rst_n          = 1'b0;
    status_clr     = 1'b0;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end

    // Reset state
    #12;
    check_eq("reset_resp", 32'({bus.resp_valid, bus.resp_id, bus.resp_result, bus.resp_exception,
                                bus.resp_overflow, bus.resp_underflow}), 32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_status", 32'({status_exception, status_overflow, status_underflow}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single operation from requester 2: 1.5 * 1.5 = 2.25
    bus.resp_ready = 1'b1;
    lat_chk        = 1'b1;
    r0             = n_resp;
    push_op(2, 16'h3FC0, 16'h3FC0, 16'h4010, 3'b000);
    drive();
    drain(20, used);
    check_eq("single_count", n_resp - r0, 32'd1);
    check_eq("single_grant", (gnt_log.size() == 1) ? gnt_log[0] : -1, 32'd2);
    gnt_log.delete();

    // Backpressure: three requests behind a stalled consumer
    lat_chk        = 1'b0;
    bus.resp_ready = 1'b0;
    push_op(0, FP_ONE,   16'h4000, 16'h4000, 3'b000);
    push_op(1, 16'h4000, 16'h4000, 16'h4080, 3'b000);
    push_op(3, 16'h3FC0, 16'h4000, 16'h4040, 3'b000);
    drive();
    repeat (5) tick();
    check_eq("bp_accepted", gnt_log.size(), 32'd2);
    check_eq("bp_busy", 32'(busy), 32'd1);
    bus.resp_ready = 1'b1;
    r0             = n_resp;
    drain(20, used);
    check_eq("bp_count", n_resp - r0, 32'd3);
    check_eq("bp_drain_cycles", used, 32'd3);
    check_eq("bp_grants", gnt_log.size(), 32'd3);
    for (int k = 0; k < gnt_log.size() && k < 3; k++) check_eq("bp_order", gnt_log[k], exp_bp[k]);
    gnt_log.delete();

    // Overflow and underflow flags
    push_op(1, 16'h7F00, 16'h7F00, 16'h7F80, 3'b010);
    push_op(2, 16'h0080, 16'h0080, FP_ZERO,  3'b001);
    drive();
    drain(20, used);
`ifdef FP_MUL_STICKY_FLAGS_EN
    check_eq("sticky_set", 32'({status_exception, status_overflow, status_underflow}), 32'b011);
    repeat (2) tick();
    check_eq("sticky_hold", 32'({status_exception, status_overflow, status_underflow}), 32'b011);
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
    check_eq("sticky_clr", 32'({status_exception, status_overflow, status_underflow}), 32'd0);
`else
    check_eq("status_off", 32'({status_exception, status_overflow, status_underflow}), 32'd0);
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
    check_eq("status_off_clr", 32'({status_exception, status_overflow, status_underflow}), 32'd0);
`endif
    gnt_log.delete();

    // Reset with both stages full; pointer is left at 2 beforehand
    bus.resp_ready = 1'b0;
    push_op(1, FP_ONE, 16'h4000, 16'h4000, 3'b000);
    push_op(2, FP_ONE, 16'h4000, 16'h4000, 3'b000);
    drive();
    tick();
    tick();
    check_eq("full_busy", 32'(busy), 32'd1);
    check_eq("full_valid", 32'(bus.resp_valid), 32'd1);
    for (int i = 0; i < NUM_REQ; i++) head[i] = tail[i];
    drive();
    rst_n = 1'b0;
    sb.delete();
    gnt_log.delete();
    held_v = 1'b0;
    #2;
    check_eq("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b1;
    r0             = n_resp;
    repeat (3) tick();
    check_eq("no_stale", n_resp - r0, 32'd0);

    // Full contention: grants must start at requester 0 and rotate one per cycle
    lat_chk = 1'b1;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < NUM_REQ; i++) push_op(i, FP_ONE, 16'h4000, 16'h4000, 3'b000);
    drive();
    drain(60, used);
    check_eq("rr_grants", gnt_log.size(), 32'd12);
    for (int k = 0; k < gnt_log.size() && k < 12; k++)
      check_eq("rr_order", gnt_log[k], k % NUM_REQ);
    check_eq("rr_cycles", used, 32'd14);
    check_eq("idle_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
